// File: rtl/drum_audio_fifo_writer.sv
// ---------------------------------------------------------------------------
// drum_audio_fifo_writer
//
// Takes one signed drum sample per valid/ready handshake and pushes it into
// the audio core through the bus-master bridge. For each sample it:
//   1. reads the FIFO-space register (AUDIO_BASE+4), retrying while either
//      the left or the right write space is zero,
//   2. writes the left-justified sample to the left data register (+8),
//   3. writes the same word to the right data register (+12).
// A bus request that sees no acknowledge within ACK_TIMEOUT cycles is
// abandoned. The sample is dropped and a sticky error flag is set.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   sample_in/valid/ready signed sample input handshake
//   bus_*                 registered request side of the bus-master bridge;
//                         bus_ack/bus_read_data come back from the bridge
//   sample_count          number of samples written to both channels
//   timeout_err           sticky, set when any bus request times out
// ---------------------------------------------------------------------------
module drum_audio_fifo_writer #(
    parameter int          SAMPLE_W    = 18,
    parameter logic [15:0] AUDIO_BASE  = 16'h3040,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [15:0]                bus_address,
    output logic [3:0]                 bus_byte_enable,
    output logic                       bus_read,
    output logic                       bus_write,
    output logic [31:0]                bus_write_data,
    input  logic                       bus_ack,
    input  logic [31:0]                bus_read_data,
    output logic [31:0]                sample_count,
    output logic                       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SPACE,
        RD_CHECK,
        GAP,
        WR_LEFT,
        GAP_W,
        WR_RIGHT
    } state_t;

    state_t                     state;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic                       space_ok;
    logic [31:0]                wait_cnt;
    logic                       wait_expired;

    // Sign-extend to 32 bits, then shift so the sample MSB lands in bit 31
    // and the unused LSBs are zero.
    function automatic logic [31:0] left_justify(input logic signed [SAMPLE_W-1:0] s);
        logic signed [31:0] ext;
        ext = 32'(s);
        return ext << (32 - SAMPLE_W);
    endfunction

    assign sample_ready = (state == IDLE);

    // The cycle now ending is the ACK_TIMEOUT-th without an acknowledge.
    assign wait_expired = (wait_cnt == 32'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            sample_q        <= '0;
            space_ok        <= 1'b0;
            wait_cnt        <= '0;
            bus_address     <= '0;
            bus_byte_enable <= '0;
            bus_read        <= 1'b0;
            bus_write       <= 1'b0;
            bus_write_data  <= '0;
            sample_count    <= '0;
            timeout_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        sample_q        <= sample_in;
                        bus_read        <= 1'b1;
                        bus_address     <= AUDIO_BASE + 16'd4;
                        bus_byte_enable <= 4'hF;
                        wait_cnt        <= '0;
                        state           <= RD_SPACE;
                    end
                end

                RD_SPACE: begin
                    if (bus_ack) begin
                        bus_read        <= 1'b0;
                        bus_byte_enable <= 4'h0;
                        // Both left and right write-space fields must be non-zero.
                        space_ok        <= (bus_read_data[31:24] != 8'd0) &&
                                           (bus_read_data[23:16] != 8'd0);
                        state           <= RD_CHECK;
                    end else if (wait_expired) begin
                        bus_read        <= 1'b0;
                        bus_byte_enable <= 4'h0;
                        timeout_err     <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                // Request lines are already low here, so the next request is
                // separated from the read by at least this cycle.
                RD_CHECK: begin
                    if (space_ok) begin
                        bus_write       <= 1'b1;
                        bus_address     <= AUDIO_BASE + 16'd8;
                        bus_write_data  <= left_justify(sample_q);
                        bus_byte_enable <= 4'hF;
                        wait_cnt        <= '0;
                        state           <= WR_LEFT;
                    end else begin
                        state <= GAP;
                    end
                end

                GAP: begin
                    bus_read        <= 1'b1;
                    bus_address     <= AUDIO_BASE + 16'd4;
                    bus_byte_enable <= 4'hF;
                    wait_cnt        <= '0;
                    state           <= RD_SPACE;
                end

                WR_LEFT: begin
                    if (bus_ack) begin
                        bus_write       <= 1'b0;
                        bus_byte_enable <= 4'h0;
                        state           <= GAP_W;
                    end else if (wait_expired) begin
                        bus_write       <= 1'b0;
                        bus_byte_enable <= 4'h0;
                        timeout_err     <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                // Write data is unchanged; only the address moves to the right channel.
                GAP_W: begin
                    bus_write       <= 1'b1;
                    bus_address     <= AUDIO_BASE + 16'd12;
                    bus_byte_enable <= 4'hF;
                    wait_cnt        <= '0;
                    state           <= WR_RIGHT;
                end

                WR_RIGHT: begin
                    if (bus_ack) begin
                        bus_write       <= 1'b0;
                        bus_byte_enable <= 4'h0;
                        sample_count    <= sample_count + 32'd1;
                        state           <= IDLE;
                    end else if (wait_expired) begin
                        bus_write       <= 1'b0;
                        bus_byte_enable <= 4'h0;
                        timeout_err     <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                default: begin
                    bus_read        <= 1'b0;
                    bus_write       <= 1'b0;
                    bus_byte_enable <= 4'h0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule
